// File: rtl/quad_gate_pkg.sv
// Shared types and the expected-gate-function helper for the quad 2-input gate tester.
package quad_gate_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [1:0] OP_AND  = 2'd0;
  localparam logic [1:0] OP_OR   = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  function automatic logic [3:0] gate_fn(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    logic [3:0] y;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = a & b;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/quad_gate_tester_sync2.sv
// Two-flop synchronizer for the asynchronous gate outputs coming back from the chip under test.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/quad_gate_tester.sv
// Exhaustive 256-vector sequencer for a quad 2-input gate chip: drive, settle, check, report.
module quad_gate_tester
  import quad_gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int GATE_OP       = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic [7:0] first_fail_vec,
  output logic [3:0] first_fail_gate,
  output logic [3:0] dut_a,
  output logic [3:0] dut_b,
  input  logic [3:0] dut_y
);

  if (SETTLE_CYCLES < 3 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("quad_gate_tester: SETTLE_CYCLES must be within 3..255");
  end
  if (GATE_OP < 0 || GATE_OP > 3) begin : g_bad_op
    $error("quad_gate_tester: GATE_OP must be within 0..3");
  end

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [1:0] OP_SEL      = 2'(GATE_OP);

  logic [3:0] sync_y;

  sync2 #(.WIDTH(4)) u_sync_y (
    .clock (clock),
    .reset (reset),
    .d     (dut_y),
    .q     (sync_y)
  );

  state_t     state_d, state_q;
  logic [7:0] vec_d, vec_q;
  logic [7:0] settle_d, settle_q;
  logic       fail_flag_d, fail_flag_q;
  logic       busy_d, busy_q;
  logic       done_d, done_q;
  logic       pass_d, pass_q;
  logic [8:0] err_count_d, err_count_q;
  logic [7:0] ffv_d, ffv_q;
  logic [3:0] ffg_d, ffg_q;
  logic [3:0] dut_a_d, dut_a_q;
  logic [3:0] dut_b_d, dut_b_q;
  logic [3:0] mism;

  // Compare against the inputs actually on the pins, not the vector counter.
  assign mism = sync_y ^ gate_fn(OP_SEL, dut_a_q, dut_b_q);

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    settle_d    = settle_q;
    fail_flag_d = fail_flag_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_count_d = err_count_q;
    ffv_d       = ffv_q;
    ffg_d       = ffg_q;
    dut_a_d     = dut_a_q;
    dut_b_d     = dut_b_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          err_count_d = '0;
          ffv_d       = '0;
          ffg_d       = '0;
          fail_flag_d = 1'b0;
          vec_d       = '0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          state_d     = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        dut_a_d  = vec_q[3:0];
        dut_b_d  = vec_q[7:4];
        settle_d = SETTLE_LOAD;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == 8'd0) begin
          state_d = ST_CHECK;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      ST_CHECK: begin
        if (mism != 4'd0) begin
          err_count_d = err_count_q + 9'd1;
          if (!fail_flag_q) begin
            ffv_d       = vec_q;
            ffg_d       = mism;
            fail_flag_d = 1'b1;
          end
        end
        if (vec_q == 8'hFF) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_q == 9'd0) && (mism == 4'd0);
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 8'd1;
          state_d = ST_DRIVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      settle_q    <= '0;
      fail_flag_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      ffv_q       <= '0;
      ffg_q       <= '0;
      dut_a_q     <= '0;
      dut_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      settle_q    <= settle_d;
      fail_flag_q <= fail_flag_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_count_q <= err_count_d;
      ffv_q       <= ffv_d;
      ffg_q       <= ffg_d;
      dut_a_q     <= dut_a_d;
      dut_b_q     <= dut_b_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_count_q;
  assign first_fail_vec  = ffv_q;
  assign first_fail_gate = ffg_q;
  assign dut_a           = dut_a_q;
  assign dut_b           = dut_b_q;

endmodule

// File: tb/tb_quad_gate_tester.sv
// Bench: two testers (AND expectation, NAND expectation) share one faultable AND-chip model.
module tb_quad_gate_tester;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, start;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [8:0] err0, err1;
  logic [7:0] ffv0, ffv1;
  logic [3:0] ffg0, ffg1, a0, b0, a1, b1, y0, y1;

  // Per-vector XOR fault mask applied on top of an ideal 7408.
  logic [3:0] fault_tbl [256];

  assign y0 = (a0 & b0) ^ fault_tbl[{b0, a0}];
  assign y1 = (a1 & b1) ^ fault_tbl[{b1, a1}];

  quad_gate_tester #(.SETTLE_CYCLES(4), .GATE_OP(0)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .first_fail_vec(ffv0), .first_fail_gate(ffg0),
    .dut_a(a0), .dut_b(b0), .dut_y(y0)
  );

  quad_gate_tester #(.SETTLE_CYCLES(3), .GATE_OP(3)) dut_nand (
    .clock(clock), .reset(reset), .start(start), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_vec(ffv1), .first_fail_gate(ffg1),
    .dut_a(a1), .dut_b(b1), .dut_y(y1)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_fn(input int op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  // Walk all 256 vectors against the chip model and tally what the tester should report.
  task automatic model(input int op, output int err, output logic [7:0] fv, output logic [3:0] fg);
    logic [7:0] v8;
    logic [3:0] m;
    err = 0; fv = 8'h00; fg = 4'h0;
    for (int v = 0; v < 256; v++) begin
      v8 = v[7:0];
      m = ((v8[3:0] & v8[7:4]) ^ fault_tbl[v]) ^ ref_fn(op, v8[3:0], v8[7:4]);
      if (m != 4'h0) begin
        if (err == 0) begin fv = v8; fg = m; end
        err++;
      end
    end
  endtask

  task automatic clear_faults();
    for (int v = 0; v < 256; v++) fault_tbl[v] = 4'h0;
  endtask

  task automatic random_faults();
    for (int v = 0; v < 256; v++)
      fault_tbl[v] = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
  endtask

  localparam int RUN_EDGES = 256 * (4 + 2);

  task automatic wait_done(output int n);
    n = 0;
    while (done0 !== 1'b1 && n < 3000) begin
      @(posedge clock); n++; @(negedge clock);
    end
  endtask

  task automatic check_main(input string name);
    int e; logic [7:0] fv; logic [3:0] fg;
    model(0, e, fv, fg);
    check({name, ".err"}, 32'(err0), 32'(e));
    check({name, ".pass"}, 32'(pass0), 32'(e == 0));
    check({name, ".ffv"}, 32'(ffv0), 32'(fv));
    check({name, ".ffg"}, 32'(ffg0), 32'(fg));
    check({name, ".busy"}, 32'(busy0), 0);
    check({name, ".a_hold"}, 32'({b0, a0}), 32'h0FF);
    $display("run %s: err_count=%0d first_fail_vec=%02h first_fail_gate=%b pass=%0d",
             name, err0, ffv0, ffg0, pass0);
  endtask

  task automatic do_run(input string name);
    int n, e; logic [7:0] fv; logic [3:0] fg;
    @(negedge clock); start = 1'b1;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    check({name, ".busy_rise"}, 32'(busy0), 1);
    check({name, ".done_drop"}, 32'(done0), 0);
    wait_done(n);
    check({name, ".edges"}, 32'(n), 32'(RUN_EDGES));
    check_main(name);
    model(3, e, fv, fg);
    check({name, ".nand_done"}, 32'(done1), 1);
    check({name, ".nand_err"}, 32'(err1), 32'(e));
    check({name, ".nand_ffv"}, 32'(ffv1), 32'(fv));
    check({name, ".nand_ffg"}, 32'(ffg1), 32'(fg));
    check({name, ".nand_pass"}, 32'(pass1), 32'(e == 0));
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    clear_faults();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst.busy", 32'(busy0), 0);
    check("rst.done", 32'(done0), 0);
    check("rst.pass", 32'(pass0), 0);
    check("rst.err", 32'(err0), 0);
    check("rst.ffv_ffg", 32'({ffv0, ffg0}), 0);
    check("rst.ab", 32'({b0, a0}), 0);
    reset = 1'b0;

    do_run("clean");

    clear_faults();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] v8;
      v8 = v[7:0];
      if (v8[2] && v8[6]) fault_tbl[v] = 4'b0100;
    end
    do_run("stuck_g2");

    clear_faults();
    fault_tbl[8'hC3] = 4'b0001;
    do_run("single_c3");

    for (int r = 0; r < 3; r++) begin
      random_faults();
      do_run($sformatf("random%0d", r));
    end

    // Start held high for the whole run: one run only, then an immediate restart.
    random_faults();
    fault_tbl[8'h11] = 4'b1000;
    @(negedge clock); start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    wait_done(n);
    check("hold.edges", 32'(n), 32'(RUN_EDGES));
    check_main("hold");
    @(posedge clock);
    @(negedge clock);
    check("hold.restart_busy", 32'(busy0), 1);
    check("hold.restart_done", 32'(done0), 0);
    check("hold.restart_err", 32'(err0), 0);
    check("hold.restart_ff", 32'({ffv0, ffg0, pass0}), 0);
    start = 1'b0;

    // Abort with reset during the SETTLE of vector 8'h80.
    n = 0;
    while (!(a0 == 4'h0 && b0 == 4'h8) && n < 3000) begin
      @(posedge clock); n++; @(negedge clock);
    end
    check("abort.reached_80", 32'(n < 3000), 1);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("abort.busy", 32'(busy0), 0);
    check("abort.done", 32'(done0), 0);
    check("abort.ab", 32'({b0, a0}), 0);
    check("abort.err", 32'(err0), 0);
    $display("run abort: busy=%0d dut_a=%h dut_b=%h err_count=%0d", busy0, a0, b0, err0);
    reset = 1'b0;

    random_faults();
    do_run("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
